// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//
// Owns the single write port of a small register file. Two writeback
// requesters share it through valid/ready handshakes with round-robin
// priority. After every reset the block first sweeps INIT_VALUE into every
// register, one register per cycle. Only then does it accept requests.
//
// The regfile write port (regwrite/writereg/writedata) is driven straight
// from flops. An accepted request therefore reaches the regfile one cycle
// after its handshake.
//
// Ports:
//   clock       system clock, rising-edge active
//   reset       asynchronous active-low reset
//   req0_valid  requester 0 has a write pending
//   req0_ready  requester 0 write accepted this cycle
//   req0_reg    requester 0 target register
//   req0_data   requester 0 write data
//   req1_valid  requester 1 has a write pending
//   req1_ready  requester 1 write accepted this cycle
//   req1_reg    requester 1 target register
//   req1_data   requester 1 write data
//   regwrite    regfile write enable (registered)
//   writereg    regfile write index (registered)
//   writedata   regfile write data (registered)
//   grant       requester of the most recent accepted write (registered)
//   init_done   high once the init sweep has been issued (registered)
module regfile_wr_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    NUM_REGS   = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  regwrite,
  output logic [ADDR_WIDTH-1:0] writereg,
  output logic [DATA_WIDTH-1:0] writedata,
  output logic                  grant,
  output logic                  init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;

  // Selection. When both requesters are valid, the one that did NOT win the
  // last accepted write goes first. grant resets to 1, so req0 wins the first
  // contention after reset. Nothing is granted while the init sweep runs.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == ST_RUN) begin
      if (req0_valid && req1_valid) begin
        req0_ready = grant;
        req1_ready = ~grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      regwrite  <= 1'b0;
      writereg  <= '0;
      writedata <= '0;
      grant     <= 1'b1;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // Issue one init write per cycle, in register-index order.
          regwrite  <= 1'b1;
          writereg  <= cnt;
          writedata <= INIT_VALUE;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (req0_valid && req0_ready) begin
            regwrite  <= 1'b1;
            writereg  <= req0_reg;
            writedata <= req0_data;
            grant     <= 1'b0;
          end else if (req1_valid && req1_ready) begin
            regwrite  <= 1'b1;
            writereg  <= req1_reg;
            writedata <= req1_data;
            grant     <= 1'b1;
          end else begin
            // With no transfer, only the enable drops. Index, data and grant
            // keep their last values.
            regwrite <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
